// File: rtl/dma_ll_fetch_if.sv
// dma_ll_fetch_if: link-request, config attribute and AXI4 read-channel bundle for dma_ll_fetch
interface dma_ll_fetch_if #(parameter int ID_W = 4);
  logic ll_req;
  logic [31:0] ll_addr;
  logic ll_ack;
  logic ll_dvld;
  logic [2:0] ll_dcnt;
  logic [31:0] ll_rdata;
  logic ll_err;
  logic cfg_dma_halt;
  logic cfg_bf;
  logic cfg_cf;
  logic m_arvalid;
  logic m_arready;
  logic [ID_W-1:0] m_arid;
  logic [31:0] m_araddr;
  logic [7:0] m_arlen;
  logic [2:0] m_arsize;
  logic [1:0] m_arburst;
  logic [3:0] m_arcache;
  logic m_rvalid;
  logic m_rready;
  logic [31:0] m_rdata;
  logic [1:0] m_rresp;
  logic m_rlast;
  modport master (
    input ll_req, ll_addr, cfg_dma_halt, cfg_bf, cfg_cf, m_arready, m_rvalid, m_rdata, m_rresp, m_rlast,
    output ll_ack, ll_dvld, ll_dcnt, ll_rdata, ll_err, m_arvalid, m_arid, m_araddr, m_arlen, m_arsize,
    m_arburst, m_arcache, m_rready
  );
  modport slave (
    output ll_req, ll_addr, cfg_dma_halt, cfg_bf, cfg_cf, m_arready, m_rvalid, m_rdata, m_rresp, m_rlast,
    input ll_ack, ll_dvld, ll_dcnt, ll_rdata, ll_err, m_arvalid, m_arid, m_araddr, m_arlen, m_arsize,
    m_arburst, m_arcache, m_rready
  );
endinterface

// File: rtl/dma_ll_fetch.sv
// dma_ll_fetch: AXI4 linked-list descriptor fetcher splitting bursts at 4KB; DMA_LL_TIMEOUT_EN adds a watchdog
module dma_ll_fetch #(
  parameter int ID_W = 4,
  parameter logic [ID_W-1:0] ARID_VAL = 4'h1,
  parameter int DESC_WORDS = 6,
  parameter int TIMEOUT_CYC = 1024
) (
  input logic clk,
  input logic rst,
  dma_ll_fetch_if.master bus
);
  localparam logic [2:0] IDLE = 3'd0, ADDR0 = 3'd1, DATA0 = 3'd2, ADDR1 = 3'd3, DATA1 = 3'd4;
  localparam logic [2:0] NW = 3'(DESC_WORDS);
  logic [2:0] state_q, state_d, cnt_q, cnt_d, dcnt_q, dcnt_d, w1;
  logic [31:0] base_q, base_d, rdata_q, rdata_d;
  logic bf_q, bf_d, cf_q, cf_d, err_q, err_d, ack_q, ack_d, dvld_q, dvld_d, lerr_q, lerr_d;
  logic [10:0] room;
  logic ar_hs, r_hs, burst_last, bad, tmo_fire;
  assign room = 11'd1024 - {1'b0, base_q[11:2]};
  assign w1 = room >= 11'(DESC_WORDS) ? NW : room[2:0];
  assign ar_hs = bus.m_arvalid & bus.m_arready;
  assign r_hs = bus.m_rvalid & bus.m_rready;
  assign burst_last = cnt_q == (state_q == DATA0 ? w1 : NW) - 3'd1;
  assign bad = bus.m_rresp[1] | (bus.m_rlast != burst_last);
  assign bus.m_arvalid = state_q == ADDR0 || state_q == ADDR1;
  assign bus.m_rready = state_q == DATA0 || state_q == DATA1;
  assign bus.m_araddr = state_q == ADDR0 ? base_q : state_q == ADDR1 ? {base_q[31:12] + 20'd1, 12'h000} : '0;
  assign bus.m_arlen = state_q == ADDR0 ? {5'd0, w1 - 3'd1} : state_q == ADDR1 ? {5'd0, NW - w1 - 3'd1} : '0;
  assign bus.m_arid = ARID_VAL;
  assign bus.m_arsize = 3'b010;
  assign bus.m_arburst = 2'b01;
  assign bus.m_arcache = {2'b00, cf_q, bf_q};
  assign bus.ll_ack = ack_q;
  assign bus.ll_dvld = dvld_q;
  assign bus.ll_dcnt = dcnt_q;
  assign bus.ll_rdata = rdata_q;
  assign bus.ll_err = lerr_q;
`ifdef DMA_LL_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] tmo_q, tmo_d;
  always_comb begin
    tmo_d = (state_q == IDLE || ar_hs || r_hs) ? '0 : tmo_q + 1'b1;
    tmo_fire = tmo_d == TW'(TIMEOUT_CYC);
  end
  always_ff @(posedge clk) tmo_q <= rst ? '0 : tmo_d;
`else
  assign tmo_fire = TIMEOUT_CYC < 0;
`endif
  always_comb begin
    state_d = state_q;
    base_d = base_q;
    bf_d = bf_q;
    cf_d = cf_q;
    cnt_d = r_hs ? cnt_q + 3'd1 : cnt_q;
    err_d = err_q | (r_hs & bad);
    ack_d = state_q == ADDR0 && ar_hs;
    dvld_d = r_hs & ~err_d;
    dcnt_d = dvld_d ? cnt_q : '0;
    rdata_d = dvld_d ? bus.m_rdata : '0;
    lerr_d = tmo_fire | (r_hs & (cnt_q == NW - 3'd1) & err_d);
    if (state_q == IDLE && bus.ll_req && !bus.cfg_dma_halt) begin
      state_d = ADDR0;
      base_d = {bus.ll_addr[31:2], 2'b00};
      bf_d = bus.cfg_bf;
      cf_d = bus.cfg_cf;
      cnt_d = '0;
      err_d = 1'b0;
    end else if (ar_hs) state_d = state_q == ADDR0 ? DATA0 : DATA1;
    else if (r_hs && burst_last) state_d = (state_q == DATA0 && w1 != NW) ? ADDR1 : IDLE;
    if (tmo_fire) state_d = IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      base_q <= '0;
      bf_q <= 1'b0;
      cf_q <= 1'b0;
      cnt_q <= '0;
      err_q <= 1'b0;
      ack_q <= 1'b0;
      dvld_q <= 1'b0;
      dcnt_q <= '0;
      rdata_q <= '0;
      lerr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      base_q <= base_d;
      bf_q <= bf_d;
      cf_q <= cf_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
      ack_q <= ack_d;
      dvld_q <= dvld_d;
      dcnt_q <= dcnt_d;
      rdata_q <= rdata_d;
      lerr_q <= lerr_d;
    end
  end
endmodule

// File: doc/dma_ll_fetch.md
Name: dma_ll_fetch

Overview:
- Linked-list descriptor fetcher, directly downstream of the DMA register/config block's `link` requester port.
- On a request, it reads one 6-word descriptor from memory over an AXI4 read channel, 32-bit data.
- It streams the words back one per beat with an index (0..5) so the config block can overwrite SAR, DAR, XSIZE, YSIZE, YSTEP and LLR, then restart the DMA on word 5.

Parameters:
- ID_W, 4, AXI ARID width.
- ARID_VAL, 4'h1, constant ARID driven on every burst.
- DESC_WORDS, 6, words per descriptor; fixed, other values unsupported.
- TIMEOUT_CYC, 1024, watchdog limit; used only with DMA_LL_TIMEOUT_EN.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- ll_req  in  1  descriptor fetch request, held until ll_ack
- ll_addr  in  32  descriptor byte address (cfg_llr)
- ll_ack  out  1  one-cycle pulse: request accepted
- ll_dvld  out  1  descriptor word valid, one cycle per word
- ll_dcnt  out  3  word index 0..5 qualified by ll_dvld
- ll_rdata  out  32  descriptor word
- ll_err  out  1  one-cycle pulse: fetch failed
- cfg_dma_halt  in  1  1 = do not accept new requests
- cfg_bf  in  1  bufferable attribute
- cfg_cf  in  1  cacheable attribute
- m_arvalid / m_arready  out/in  1 / 1  AR handshake
- m_arid  out  ID_W  = ARID_VAL
- m_araddr  out  32  burst start address
- m_arlen  out  8  beats-1
- m_arsize  out  3  constant 3'b010
- m_arburst  out  2  constant 2'b01 (INCR)
- m_arcache  out  4  {2'b00, cf_q, bf_q}
- m_rvalid / m_rready  in/out  1 / 1  R handshake
- m_rdata  in  32  read data
- m_rresp  in  2  read response
- m_rlast  in  1  last beat

Behaviour:
- Reset: rst sampled on the clk edge.
  - State returns to IDLE.
  - All outputs drive 0, except the constant fields arsize, arburst and arid.
  - Reset mid-burst abandons the transaction with no AXI cleanup; use rst only as a system reset.
- FSM states:
  - IDLE → ADDR0 when ll_req=1 and cfg_dma_halt=0. On this transition:
    - latch base = {ll_addr[31:2], 2'b00}
    - latch bf_q, cf_q
    - clear the beat counter and the error flag.
  - ADDR0: m_arvalid=1, araddr=base, arlen=w1-1.
    - w1 = min(6, (0x1000 - base[11:0]) >> 2); bursts never cross a 4KB boundary.
    - On arvalid&arready → DATA0, and ll_ack pulses in the following cycle (registered).
  - DATA0: m_rready=1.
    - After w1 beats: → ADDR1 if w1<6, else → IDLE.
  - ADDR1: araddr = {base[31:12]+1, 12'h000}, arlen = 6-w1-1. On handshake → DATA1.
  - DATA1: m_rready=1. After 6-w1 beats → IDLE.
- Request handling:
  - ll_req is ignored outside IDLE. A still-high ll_req in the ll_ack cycle is not re-accepted.
  - cfg_dma_halt blocks only the IDLE→ADDR0 transition; an in-flight fetch completes.
- Data path:
  - Each R handshake registers, one cycle later: ll_dvld=1, ll_rdata=m_rdata, ll_dcnt=beat counter.
  - The beat counter increments per beat across both bursts (0..5), so ll_dcnt is contiguous through a split.
  - m_arvalid stays high until arready; address and length are stable while waiting.
- Errors:
  - Triggers: rresp[1]=1 on any beat, or rlast mismatching the expected last beat of the current burst.
  - Effect: the error flag is set, and ll_dvld is suppressed for that beat and all remaining beats of the descriptor.
  - Remaining beats are still accepted, and termination is by beat count (never by rlast).
  - ll_err pulses one cycle when the last expected beat is accepted.
  - Words delivered before the error are not retracted. Since word 5 is never delivered, the downstream DMA does not restart.
- Simultaneous events: ll_ack and ll_dvld never occur in the same cycle. The first dvld is at the earliest 1 cycle after ll_ack.

Optional Feature:
- Macro DMA_LL_TIMEOUT_EN.
- Defined:
  - A counter runs in ADDR*/DATA* and is cleared on every AR or R handshake.
  - On reaching TIMEOUT_CYC: ll_err pulses, the FSM → IDLE, and m_arvalid and m_rready drop.
  - Late beats are not consumed; recovery requires rst.
- Undefined: no counter; the fetcher waits indefinitely.

Test Plan:
- ll_addr=0x0000_1000, ll_req held, arready=1, six OKAY beats D0..D5 → one AR: araddr=0x1000, arlen=5, arcache=0; ll_ack 1-cycle pulse; ll_dvld with dcnt 0..5 carrying D0..D5, each 1 cycle after its R handshake; ll_err=0.
- ll_addr=0x0000_1FF3, bf=1, cf=1 → AR1: 0x1FF0 arlen=3; AR2: 0x2000 arlen=1; arcache=4'b0011 on both; dcnt 0..5 contiguous; single ll_ack.
- rresp=2'b10 on beat 2 → dvld for dcnt 0,1 only; beats 3..5 still accepted; one ll_err pulse on beat 5 acceptance; FSM back in IDLE.
- cfg_dma_halt=1 with ll_req=1 for 20 cycles → no arvalid, no ll_ack; halt→0 → arvalid next cycle.
- rst asserted in DATA0 after beat 2 → next cycle all outputs 0, state IDLE; a new ll_req is accepted normally.
- With DMA_LL_TIMEOUT_EN and TIMEOUT_CYC=16, rvalid held 0 after AR → ll_err pulse 16 cycles after the AR handshake, rready=0, IDLE.
